// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
// regfile_wb_arbiter
//   Two-requester round-robin arbiter for a single register-file write port.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module regfile_wb_arbiter (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        ValidA,
    input  logic [4:0]  AddrA,
    input  logic [31:0] DataA,
    output logic        ReadyA,
    input  logic        ValidB,
    input  logic [4:0]  AddrB,
    input  logic [31:0] DataB,
    output logic        ReadyB,
    output logic        RegWrite,
    output logic [4:0]  WriteRegister,
    output logic [31:0] WriteData,
    output logic        DroppedZero,
    output logic [15:0] WriteCount
);

    localparam logic [0:0]  PRIO_A    = 1'b0;
    localparam logic [0:0]  PRIO_B    = 1'b1;
    localparam logic [15:0] COUNT_MAX = 16'hFFFF;

    logic [0:0]  prio;
    logic [0:0]  prio_next;
    logic        grant_a;
    logic        grant_b;
    logic        accept;
    logic [4:0]  sel_addr;
    logic [31:0] sel_data;

    // Grants are pure functions of the inputs and the priority bit; reset blocks both.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!Reset) begin
            grant_a = ValidA && (!ValidB || (prio == PRIO_A));
            grant_b = ValidB && (!ValidA || (prio == PRIO_B));
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            prio <= PRIO_A;
        end else begin
            prio <= prio_next;
        end
    end

    always_comb begin
        prio_next = prio;
        if (grant_a) begin
            prio_next = PRIO_B;
        end else if (grant_b) begin
            prio_next = PRIO_A;
        end
    end

    always_comb begin
        ReadyA = grant_a;
        ReadyB = grant_b;
    end

    assign accept   = grant_a || grant_b;
    assign sel_addr = grant_b ? AddrB : AddrA;
    assign sel_data = grant_b ? DataB : DataA;

    // Writes to register 0 still load the address/data but are reported as dropped.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            RegWrite      <= 1'b0;
            DroppedZero   <= 1'b0;
            WriteRegister <= 5'd0;
            WriteData     <= 32'd0;
            WriteCount    <= 16'd0;
        end else if (accept) begin
            RegWrite      <= (sel_addr != 5'd0);
            DroppedZero   <= (sel_addr == 5'd0);
            WriteRegister <= sel_addr;
            WriteData     <= sel_data;
            if ((sel_addr != 5'd0) && (WriteCount != COUNT_MAX)) begin
                WriteCount <= WriteCount + 16'd1;
            end
        end else begin
            RegWrite    <= 1'b0;
            DroppedZero <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
// ============================================================================
// tb_regfile_wb_arbiter
//   Randomized scoreboard bench for regfile_wb_arbiter.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module tb_regfile_wb_arbiter;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        ValidA = 1'b0;
    logic [4:0]  AddrA = 5'd0;
    logic [31:0] DataA = 32'd0;
    logic        ReadyA;
    logic        ValidB = 1'b0;
    logic [4:0]  AddrB = 5'd0;
    logic [31:0] DataB = 32'd0;
    logic        ReadyB;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic        DroppedZero;
    logic [15:0] WriteCount;

    regfile_wb_arbiter dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .ValidA        (ValidA),
        .AddrA         (AddrA),
        .DataA         (DataA),
        .ReadyA        (ReadyA),
        .ValidB        (ValidB),
        .AddrB         (AddrB),
        .DataB         (DataB),
        .ReadyB        (ReadyB),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .DroppedZero   (DroppedZero),
        .WriteCount    (WriteCount)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic        rw;
        logic        dz;
        logic [4:0]  wreg;
        logic [31:0] data;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];

    int tests = 0;
    int fails = 0;

    // Reference model: who must win the next tie, and the number of real writes.
    bit        a_wins_tie = 1'b1;
    int        model_count = 0;
    bit        last_ga;
    bit        last_gb;
    int        gcnt_a;
    int        gcnt_b;

    logic [4:0]  held_reg = 5'd0;
    logic [31:0] held_data = 32'd0;
    logic [15:0] held_cnt = 16'd0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cycle(input bit va, input logic [4:0] aa, input logic [31:0] da,
                         input bit vb, input logic [4:0] ab, input logic [31:0] db,
                         input bit rst);
        bit   ga, gb;
        exp_t e;
        @(negedge Clk);
        Reset  = rst;
        ValidA = va; AddrA = aa; DataA = da;
        ValidB = vb; AddrB = ab; DataB = db;
        #1;
        ga = 1'b0;
        gb = 1'b0;
        if (!rst) begin
            if (va && vb) begin
                ga = a_wins_tie;
                gb = !a_wins_tie;
            end else begin
                ga = va;
                gb = vb;
            end
        end
        chk("ReadyA", {63'd0, ReadyA}, {63'd0, ga});
        chk("ReadyB", {63'd0, ReadyB}, {63'd0, gb});
        last_ga = ga;
        last_gb = gb;
        if (rst) begin
            a_wins_tie  = 1'b1;
            model_count = 0;
            sb.delete();
        end else if (ga || gb) begin
            e.wreg = ga ? aa : ab;
            e.data = ga ? da : db;
            e.rw   = (e.wreg != 5'd0);
            e.dz   = (e.wreg == 5'd0);
            if (e.rw && model_count < 65535) model_count++;
            e.cnt  = 16'(model_count);
            sb.push_back(e);
            a_wins_tie = gb;
            gcnt_a += int'(ga);
            gcnt_b += int'(gb);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0);
    endtask

    // Monitor: compares every presented write/drop against the scoreboard.
    always @(posedge Clk) begin
        exp_t e;
        #1;
        if (Reset) begin
            held_reg  = 5'd0;
            held_data = 32'd0;
            held_cnt  = 16'd0;
            chk("reset_regwrite", {63'd0, RegWrite}, 64'd0);
            chk("reset_dropped", {63'd0, DroppedZero}, 64'd0);
            chk("reset_count", {48'd0, WriteCount}, 64'd0);
            chk("reset_wreg", {59'd0, WriteRegister}, 64'd0);
            chk("reset_wdata", {32'd0, WriteData}, 64'd0);
        end else if (RegWrite || DroppedZero) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", {63'd0, RegWrite}, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("regwrite", {63'd0, RegWrite}, {63'd0, e.rw});
                chk("dropped", {63'd0, DroppedZero}, {63'd0, e.dz});
                chk("wreg", {59'd0, WriteRegister}, {59'd0, e.wreg});
                chk("wdata", {32'd0, WriteData}, {32'd0, e.data});
                chk("count", {48'd0, WriteCount}, {48'd0, e.cnt});
                held_reg  = e.wreg;
                held_data = e.data;
                held_cnt  = e.cnt;
            end
        end else begin
            chk("missing_output", 64'(sb.size()), 64'd0);
            sb.delete();
            chk("hold_wreg", {59'd0, WriteRegister}, {59'd0, held_reg});
            chk("hold_wdata", {32'd0, WriteData}, {32'd0, held_data});
            chk("hold_count", {48'd0, WriteCount}, {48'd0, held_cnt});
        end
    end

    initial begin
        bit          va, vb, rst;
        logic [4:0]  aa, ab;
        logic [31:0] da, db;

        // Reset with noisy requests: nothing may be accepted.
        for (int i = 0; i < 3; i++)
            cycle(1, 5'd4, $urandom, 1, 5'd6, $urandom, 1);

        // Single request from A.
        cycle(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0, 0);
        chk("single_ready", {63'd0, last_ga}, 64'd1);
        idle(2);

        // Contention straight out of reset: A then B.
        cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1);
        cycle(1, 5'd3, 32'h11, 1, 5'd7, 32'h22, 0);
        chk("contend_first_a", {63'd0, last_ga}, 64'd1);
        cycle(0, 5'd0, 32'd0, 1, 5'd7, 32'h22, 0);
        chk("contend_second_b", {63'd0, last_gb}, 64'd1);
        idle(1);

        // Fairness over 8 cycles of continuous contention.
        gcnt_a = 0;
        gcnt_b = 0;
        for (int i = 0; i < 8; i++)
            cycle(1, 5'(1 + (i % 31)), $urandom, 1, 5'(2 + (i % 29)), $urandom, 0);
        chk("fair_a", 64'(gcnt_a), 64'd4);
        chk("fair_b", 64'(gcnt_b), 64'd4);
        idle(1);

        // Register 0 write is dropped.
        cycle(0, 5'd0, 32'd0, 1, 5'd0, 32'hFFFFFFFF, 0);
        chk("zero_ready", {63'd0, last_gb}, 64'd1);
        idle(2);

        // Reset right after an acceptance.
        cycle(1, 5'd9, 32'h5A, 0, 5'd0, 32'd0, 0);
        cycle(1, 5'd8, 32'h1, 1, 5'd10, 32'h2, 1);
        cycle(1, 5'd8, 32'h1, 1, 5'd10, 32'h2, 0);
        chk("post_reset_prio_a", {63'd0, last_ga}, 64'd1);
        idle(1);

        // Random traffic, honouring the hold rule for stalled requesters.
        va = 0; vb = 0; aa = 0; ab = 0; da = 0; db = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!(va && !last_ga)) begin
                va = ($urandom_range(0, 9) < 6);
                aa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
                da = $urandom;
            end
            if (!(vb && !last_gb)) begin
                vb = ($urandom_range(0, 9) < 6);
                ab = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
                db = $urandom;
            end
            rst = ($urandom_range(0, 99) < 2);
            cycle(va, aa, da, vb, ab, db, rst);
        end

        // Saturation: 65534 writes, then more must stick at the maximum.
        cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1);
        for (int i = 0; i < 65534; i++)
            cycle(1, 5'(1 + (i % 31)), 32'(i), 0, 5'd0, 32'd0, 0);
        idle(1);
        chk("count_fffe", {48'd0, WriteCount}, 64'hFFFE);
        for (int i = 0; i < 4; i++)
            cycle(0, 5'd0, 32'd0, 1, 5'd12, 32'(i), 0);
        idle(1);
        chk("count_saturated", {48'd0, WriteCount}, 64'hFFFF);

        idle(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have port Clk, input, 1, clock; all state updates on the positive edge.
REQ-002 SHALL have port Reset, input, 1, reset; synchronous, active-high.
REQ-003 SHALL have port ValidA, input, 1, ALU writeback request valid.
REQ-004 SHALL have port AddrA, input, 5, ALU destination register.
REQ-005 SHALL have port DataA, input, 32, ALU writeback data.
REQ-006 SHALL have port ReadyA, output, 1, ALU request accepted this cycle when ValidA is also high.
REQ-007 SHALL have port ValidB, input, 1, load writeback request valid.
REQ-008 SHALL have port AddrB, input, 5, load destination register.
REQ-009 SHALL have port DataB, input, 32, load writeback data.
REQ-010 SHALL have port ReadyB, output, 1, load request accepted this cycle when ValidB is also high.
REQ-011 SHALL have port RegWrite, output, 1, registered register-file write enable.
REQ-012 SHALL have port WriteRegister, output, 5, registered register-file write address.
REQ-013 SHALL have port WriteData, output, 32, registered register-file write data.
REQ-014 SHALL have port DroppedZero, output, 1, registered; pulses for one cycle when an accepted request targeted register 0.
REQ-015 SHALL have port WriteCount, output, 16, saturating count of RegWrite pulses.

Function
REQ-016 SHALL arbitrate between requesters A and B for the single register-file write port, granting at most one request per cycle.
REQ-017 SHALL keep a one-bit priority state with values PRIO_A and PRIO_B.
REQ-018 SHALL, with only one requester valid, grant that requester regardless of priority.
REQ-019 SHALL, with both requesters valid, grant A in PRIO_A and B in PRIO_B.
REQ-020 SHALL drive ReadyA/ReadyB combinationally from Valid inputs and priority; the non-granted requester sees Ready=0 and must hold Valid/Addr/Data stable.
REQ-021 SHALL, after any grant, set priority to the non-granted requester (grant A -> PRIO_B, grant B -> PRIO_A); with no grant, priority is unchanged.
REQ-022 SHALL present an accepted request on WriteRegister/WriteData with RegWrite=1 exactly one cycle after acceptance (latency 1).
REQ-023 SHALL, for an accepted request with Addr=0, assert RegWrite=0 and DroppedZero=1 in the following cycle; WriteRegister/WriteData still load the request values.
REQ-024 SHALL, in a cycle with no grant, drive RegWrite=0 and DroppedZero=0 next cycle while holding WriteRegister and WriteData.
REQ-025 SHALL increment WriteCount by 1 in each cycle that RegWrite=1 and saturate at 16'hFFFF with no wrap.
REQ-026 SHALL sustain one accepted request per cycle back-to-back with no bubble.

Reset
REQ-027 SHALL, while Reset=1, force ReadyA=0 and ReadyB=0 so no request is accepted in a reset cycle.
REQ-028 SHALL, on a clock edge with Reset=1, set RegWrite=0, WriteRegister=0, WriteData=0, DroppedZero=0, WriteCount=0 and priority=PRIO_A.
REQ-029 SHALL, when Reset is asserted the cycle after an acceptance, give Reset precedence so RegWrite=0 on the next edge and that request is lost.

Verification
REQ-030 SHALL cover single request: ValidA=1, AddrA=5, DataA=32'hDEADBEEF, ValidB=0 -> ReadyA=1; next cycle RegWrite=1, WriteRegister=5, WriteData=32'hDEADBEEF, WriteCount=1.
REQ-031 SHALL cover contention: out of reset, A(3,32'h11) and B(7,32'h22) held valid -> cycle 1 grants A, cycle 2 grants B; writes of reg 3 then reg 7 on consecutive cycles.
REQ-032 SHALL cover fairness: A and B valid continuously for 8 cycles -> grants alternate A,B,A,B,...; each requester receives 4 grants.
REQ-033 SHALL cover zero register: ValidB=1, AddrB=0, DataB=32'hFFFFFFFF -> ReadyB=1; next cycle RegWrite=0, DroppedZero=1, WriteCount unchanged.
REQ-034 SHALL cover reset mid-operation: accept A(9,32'h5A), assert Reset the next cycle -> RegWrite=0, WriteCount=0, ReadyA=ReadyB=0 while Reset=1, priority PRIO_A afterward.
REQ-035 SHALL cover saturation: WriteCount preloaded to 16'hFFFE via 65534 writes, then two more writes -> WriteCount=16'hFFFF and stays at 16'hFFFF.
